// File: rtl/constants_pkg.sv
// ---------------------------------------------------------------------------
// constants_pkg
// Shared constants and types for the processor slice: memory geometry, the
// memory-mapped addresses decoded by the interrupt controller, the execution
// unit's stage encoding and the interrupt controller's state encoding.
// No ports; imported with `import constants_pkg::*;`.
// ---------------------------------------------------------------------------
package constants_pkg;

  localparam int MEMORY_ADDRESS_BITS = 8;
  localparam int MEMORY_DATA_BITS    = 8;

  // Memory-mapped interrupt controller registers, snooped off the RAM write port
  localparam logic [MEMORY_ADDRESS_BITS-1:0] INTC_MASK_ADDRESS = 8'hFE;
  localparam logic [MEMORY_ADDRESS_BITS-1:0] INTC_EOI_ADDRESS  = 8'hFF;

  // Execution unit pipeline stage
  typedef enum logic [1:0] {
    ES_FETCH,
    ES_DECODE,
    ES_EXECUTE,
    ES_WRITEBACK
  } ExecutionStage;

  // Interrupt controller handshake state
  typedef enum logic [1:0] {
    IC_IDLE,
    IC_REQUEST,
    IC_SERVICE
  } IntcState;

endpackage

// File: rtl/irq_edge_detect.sv
// ---------------------------------------------------------------------------
// irq_edge_detect
// Brings one raw asynchronous interrupt line into the clk domain through a
// 2-flop synchronizer, then compares it against a delayed copy to produce a
// single-cycle pulse on each rising edge.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   irq    in  raw interrupt line (asynchronous)
//   rise   out one-cycle pulse after a synchronized rising edge
// ---------------------------------------------------------------------------
module irq_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic rise
);

  logic sync0;
  logic sync1;
  logic prev;

  // Synchronizer pair followed by the delay flop used for edge comparison
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync0 <= irq;
      sync1 <= sync0;
      prev  <= sync1;
    end
  end

  assign rise = sync1 & ~prev;

endmodule

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
// Latches rising edges of the interrupt lines as pending, gates them with a
// software-written enable mask, picks the lowest-index eligible source and
// runs a request / acknowledge / end-of-interrupt handshake with the
// execution unit. Mask and EOI writes are picked up by snooping the execution
// unit's RAM write port.
// Ports:
//   clk          in  system clock
//   reset        in  asynchronous active-high reset
//   irq_in       in  raw interrupt lines, rising-edge sensitive
//   wr_ram_en    in  snooped RAM write strobe
//   wr_ram_addr  in  snooped RAM write address
//   wr_ram_data  in  snooped RAM write data
//   int_req      out interrupt request, high while a grant awaits acknowledge
//   int_ack      in  acknowledge from the execution unit
//   int_id       out index of the granted source
//   in_service   out high from acknowledge until EOI
//   pending      out pending edge bits (debug)
// ---------------------------------------------------------------------------
module interrupt_controller
  import constants_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int ID_BITS     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SOURCES-1:0]         irq_in,
  input  logic                           wr_ram_en,
  input  logic [MEMORY_ADDRESS_BITS-1:0] wr_ram_addr,
  input  logic [MEMORY_DATA_BITS-1:0]    wr_ram_data,
  output logic                           int_req,
  input  logic                           int_ack,
  output logic [ID_BITS-1:0]             int_id,
  output logic                           in_service,
  output logic [NUM_SOURCES-1:0]         pending
);

  IntcState                state;
  IntcState                next_state;

  logic [NUM_SOURCES-1:0]  rise;
  logic [NUM_SOURCES-1:0]  mask;
  logic [NUM_SOURCES-1:0]  eligible;
  logic [NUM_SOURCES-1:0]  mask_data_q;
  logic                    mask_write_q;
  logic                    mask_write;
  logic                    eoi;
  logic                    ack_take;
  logic                    any_eligible;
  logic [ID_BITS-1:0]      winner;

  // One synchronizer + edge detector per interrupt line
  genvar g;
  generate
    for (g = 0; g < NUM_SOURCES; g++) begin : gen_edge
      irq_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .irq   (irq_in[g]),
        .rise  (rise[g])
      );
    end
  endgenerate

  // Data bits above the mask width are never used
  generate
    if (NUM_SOURCES < MEMORY_DATA_BITS) begin : gen_unused_data
      logic unused_data_bits;
      assign unused_data_bits = ^wr_ram_data[MEMORY_DATA_BITS-1:NUM_SOURCES];
    end
  endgenerate

  assign mask_write = wr_ram_en && (wr_ram_addr == INTC_MASK_ADDRESS);
  assign eoi        = wr_ram_en && (wr_ram_addr == INTC_EOI_ADDRESS);
  assign ack_take   = (state == IC_REQUEST) && int_ack;

  // Mask writes pass through one staging register before reaching the mask,
  // so the RAM port timing path ends in a flop; a write therefore makes a
  // pending source eligible one edge after it was sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_write_q <= 1'b0;
      mask_data_q  <= '0;
      mask         <= '0;
    end else begin
      mask_write_q <= mask_write;
      mask_data_q  <= wr_ram_data[NUM_SOURCES-1:0];
      if (mask_write_q) begin
        mask <= mask_data_q;
      end
    end
  end

  // Pending bits: the acknowledged grant is cleared, but a new edge on the
  // same line in the same cycle must not be lost, so the set is applied last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (rise[i]) begin
          pending[i] <= 1'b1;
        end else if (ack_take && (int_id == ID_BITS'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  assign eligible     = pending & mask;
  assign any_eligible = |eligible;

  // Fixed priority: scanning downward lets the lowest eligible index win
  always_comb begin
    winner = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = ID_BITS'(i);
      end
    end
  end

  // Grant register: captured only when leaving IC_IDLE, so the id stays frozen
  // through request and service regardless of new arrivals or mask changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_id <= '0;
    end else if (state == IC_IDLE && any_eligible) begin
      int_id <= winner;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IC_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; EOI out of service always passes through IC_IDLE,
  // which guarantees a low cycle on int_req between consecutive requests.
  always_comb begin
    next_state = state;
    case (state)
      IC_IDLE: begin
        if (any_eligible) begin
          next_state = IC_REQUEST;
        end
      end
      IC_REQUEST: begin
        if (int_ack) begin
          next_state = IC_SERVICE;
        end
      end
      IC_SERVICE: begin
        if (eoi) begin
          next_state = IC_IDLE;
        end
      end
      default: next_state = IC_IDLE;
    endcase
  end

  // FSM outputs, decoded purely from the state register
  always_comb begin
    int_req    = 1'b0;
    in_service = 1'b0;
    case (state)
      IC_REQUEST: int_req    = 1'b1;
      IC_SERVICE: in_service = 1'b1;
      default: begin
        int_req    = 1'b0;
        in_service = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
// Directed test of interrupt_controller: edge capture, masking, priority,
// frozen grant, long acknowledge wait, stray writes and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

  logic       clk;
  logic       reset;
  logic [3:0] irq_in;
  logic       wr_ram_en;
  logic [7:0] wr_ram_addr;
  logic [7:0] wr_ram_data;
  logic       int_req;
  logic       int_ack;
  logic [1:0] int_id;
  logic       in_service;
  logic [3:0] pending;

  int total_checks;
  int failed_checks;

  interrupt_controller #(
    .NUM_SOURCES (4),
    .ID_BITS     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .wr_ram_en   (wr_ram_en),
    .wr_ram_addr (wr_ram_addr),
    .wr_ram_data (wr_ram_data),
    .int_req     (int_req),
    .int_ack     (int_ack),
    .int_id      (int_id),
    .in_service  (in_service),
    .pending     (pending)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one set of inputs for the first of 'cycles' rising edges; the
  // write strobe and acknowledge are one-shot, irq lines stay as given.
  // Returns 1 time unit after the last edge, away from the sampling edge.
  task automatic applyStimulus(input logic [3:0] irq, input logic wen,
                               input logic [7:0] addr, input logic [7:0] data,
                               input logic ack, input int cycles);
    irq_in      = irq;
    wr_ram_en   = wen;
    wr_ram_addr = addr;
    wr_ram_data = data;
    int_ack     = ack;
    @(posedge clk);
    #1;
    wr_ram_en   = 1'b0;
    wr_ram_addr = 8'h00;
    wr_ram_data = 8'h00;
    int_ack     = 1'b0;
    for (int i = 1; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total_checks++;
    assert (observed === expected)
    else begin
      failed_checks++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total_checks  = 0;
    failed_checks = 0;
    reset       = 1'b1;
    irq_in      = 4'b0000;
    wr_ram_en   = 1'b0;
    wr_ram_addr = 8'h00;
    wr_ram_data = 8'h00;
    int_ack     = 1'b0;

    // Reset state
    #2;
    checkOutput("reset_int_req", {7'b0, int_req}, 8'h00);
    checkOutput("reset_in_service", {7'b0, in_service}, 8'h00);
    checkOutput("reset_int_id", {6'b0, int_id}, 8'h00);
    checkOutput("reset_pending", {4'b0, pending}, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Source 1 pending while masked: no request
    applyStimulus(4'b0010, 1'b0, 8'h00, 8'h00, 1'b0, 3);
    checkOutput("masked_pending", {4'b0, pending}, 8'h02);
    checkOutput("masked_no_req", {7'b0, int_req}, 8'h00);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b0, 2);
    checkOutput("masked_still_no_req", {7'b0, int_req}, 8'h00);

    // Unmask source 1: request two edges after the write is sampled
    applyStimulus(4'b0000, 1'b1, 8'hFE, 8'h02, 1'b0, 1);
    checkOutput("mask_m0_req", {7'b0, int_req}, 8'h00);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b0, 1);
    checkOutput("mask_m1_req", {7'b0, int_req}, 8'h00);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b0, 1);
    checkOutput("mask_m2_req", {7'b0, int_req}, 8'h01);
    checkOutput("mask_m2_id", {6'b0, int_id}, 8'h01);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b1, 1);
    checkOutput("ack1_req", {7'b0, int_req}, 8'h00);
    checkOutput("ack1_service", {7'b0, in_service}, 8'h01);
    checkOutput("ack1_pending", {4'b0, pending}, 8'h00);
    applyStimulus(4'b0000, 1'b1, 8'hFF, 8'h00, 1'b0, 1);
    checkOutput("eoi1_service", {7'b0, in_service}, 8'h00);

    // Mask all, sources 3 and 0 together: 0 first, then 3 after a low cycle
    applyStimulus(4'b0000, 1'b1, 8'hFE, 8'h0F, 1'b0, 2);
    applyStimulus(4'b1001, 1'b0, 8'h00, 8'h00, 1'b0, 3);
    checkOutput("prio_pending", {4'b0, pending}, 8'h09);
    checkOutput("prio_k2_req", {7'b0, int_req}, 8'h00);
    applyStimulus(4'b1001, 1'b0, 8'h00, 8'h00, 1'b0, 1);
    checkOutput("prio_req", {7'b0, int_req}, 8'h01);
    checkOutput("prio_id0", {6'b0, int_id}, 8'h00);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b1, 1);
    checkOutput("prio_ack_service", {7'b0, in_service}, 8'h01);
    checkOutput("prio_ack_pending", {4'b0, pending}, 8'h08);
    applyStimulus(4'b0000, 1'b1, 8'hFF, 8'h00, 1'b0, 1);
    checkOutput("prio_gap_req", {7'b0, int_req}, 8'h00);
    checkOutput("prio_gap_service", {7'b0, in_service}, 8'h00);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b0, 1);
    checkOutput("prio_second_req", {7'b0, int_req}, 8'h01);
    checkOutput("prio_id3", {6'b0, int_id}, 8'h03);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b1, 1);
    applyStimulus(4'b0000, 1'b1, 8'hFF, 8'h00, 1'b0, 1);
    checkOutput("prio_done_pending", {4'b0, pending}, 8'h00);

    // Stray EOI in IC_IDLE
    applyStimulus(4'b0000, 1'b1, 8'hFF, 8'h00, 1'b0, 1);
    checkOutput("idle_eoi_req", {7'b0, int_req}, 8'h00);
    checkOutput("idle_eoi_service", {7'b0, in_service}, 8'h00);

    // Write to 0xFD leaves the mask at 4'b1111
    applyStimulus(4'b0000, 1'b1, 8'hFD, 8'h00, 1'b0, 2);
    applyStimulus(4'b1000, 1'b0, 8'h00, 8'h00, 1'b0, 4);
    checkOutput("fd_mask_req", {7'b0, int_req}, 8'h01);
    checkOutput("fd_mask_id", {6'b0, int_id}, 8'h03);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b1, 1);
    applyStimulus(4'b0000, 1'b1, 8'hFF, 8'h00, 1'b0, 1);

    // Grant to source 2 stays frozen when source 0 arrives
    applyStimulus(4'b0100, 1'b0, 8'h00, 8'h00, 1'b0, 4);
    checkOutput("frozen_req", {7'b0, int_req}, 8'h01);
    checkOutput("frozen_id_before", {6'b0, int_id}, 8'h02);
    applyStimulus(4'b0101, 1'b0, 8'h00, 8'h00, 1'b0, 3);
    checkOutput("frozen_pending", {4'b0, pending}, 8'h05);
    checkOutput("frozen_id_after", {6'b0, int_id}, 8'h02);
    checkOutput("frozen_req_after", {7'b0, int_req}, 8'h01);

    // 50 cycles without acknowledge, with a stray EOI in IC_REQUEST
    for (int blk = 0; blk < 5; blk++) begin
      applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b0, 10);
      checkOutput("hold_req", {7'b0, int_req}, 8'h01);
      checkOutput("hold_id", {6'b0, int_id}, 8'h02);
    end
    applyStimulus(4'b0000, 1'b1, 8'hFF, 8'h00, 1'b0, 1);
    checkOutput("req_eoi_req", {7'b0, int_req}, 8'h01);
    checkOutput("req_eoi_service", {7'b0, in_service}, 8'h00);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b1, 1);
    checkOutput("hold_ack_pending", {4'b0, pending}, 8'h01);
    checkOutput("hold_ack_service", {7'b0, in_service}, 8'h01);
    checkOutput("hold_ack_req", {7'b0, int_req}, 8'h00);
    applyStimulus(4'b0000, 1'b1, 8'hFF, 8'h00, 1'b0, 1);
    checkOutput("src0_gap_req", {7'b0, int_req}, 8'h00);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b0, 1);
    checkOutput("src0_req", {7'b0, int_req}, 8'h01);
    checkOutput("src0_id", {6'b0, int_id}, 8'h00);

    // New edge on source 0 lands in the same cycle as its acknowledge
    applyStimulus(4'b0001, 1'b0, 8'h00, 8'h00, 1'b0, 2);
    applyStimulus(4'b0001, 1'b0, 8'h00, 8'h00, 1'b1, 1);
    checkOutput("set_wins_service", {7'b0, in_service}, 8'h01);
    checkOutput("set_wins_pending", {4'b0, pending}, 8'h01);
    applyStimulus(4'b0000, 1'b1, 8'hFF, 8'h00, 1'b0, 1);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b0, 1);
    checkOutput("set_wins_rereq", {7'b0, int_req}, 8'h01);
    checkOutput("set_wins_reid", {6'b0, int_id}, 8'h00);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b1, 1);
    applyStimulus(4'b0000, 1'b1, 8'hFF, 8'h00, 1'b0, 1);

    // Asynchronous reset in IC_SERVICE
    applyStimulus(4'b0110, 1'b0, 8'h00, 8'h00, 1'b0, 4);
    checkOutput("pre_reset_id", {6'b0, int_id}, 8'h01);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b1, 1);
    checkOutput("pre_reset_service", {7'b0, in_service}, 8'h01);
    checkOutput("pre_reset_pending", {4'b0, pending}, 8'h04);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_req", {7'b0, int_req}, 8'h00);
    checkOutput("async_reset_service", {7'b0, in_service}, 8'h00);
    checkOutput("async_reset_id", {6'b0, int_id}, 8'h00);
    checkOutput("async_reset_pending", {4'b0, pending}, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // After reset the mask is clear again: edge alone does not request
    applyStimulus(4'b1000, 1'b0, 8'h00, 8'h00, 1'b0, 5);
    checkOutput("post_reset_pending", {4'b0, pending}, 8'h08);
    checkOutput("post_reset_no_req", {7'b0, int_req}, 8'h00);
    applyStimulus(4'b0000, 1'b1, 8'hFE, 8'h08, 1'b0, 2);
    checkOutput("post_reset_m1_req", {7'b0, int_req}, 8'h00);
    applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b0, 1);
    checkOutput("post_reset_req", {7'b0, int_req}, 8'h01);
    checkOutput("post_reset_id", {6'b0, int_id}, 8'h03);

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule
